// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Fetch program-counter sequencer. Each rising edge picks the next PC from, in
// falling priority: reset vector, trap vector, mret return (mepc), jump/branch
// target, and sequential PC+INC; otherwise the PC holds. Jump targets that
// are not INC-aligned are rejected with a one-cycle o_misaligned pulse. A
// small circular return-address stack (RAS) records call return addresses
// for return prediction in fetch.
//
// Ports
//   i_clk           clock, all state updates on the rising edge
//   i_rst           synchronous active-high reset
//   i_load_PC       advance enable (jump target or sequential)
//   i_jump_DV       jump/branch taken, qualified by i_load_PC
//   i_jump_address  jump/branch target
//   i_call / i_ret  accepted jump is a call (push) / return (pop)
//   i_trap          trap request, i_trap_vector is the handler address
//   i_mret          return from trap, i_mepc is the destination
//   o_PC            current PC
//   o_prev_PC       PC before the most recent update
//   o_misaligned    one-cycle pulse: jump rejected as misaligned
//   o_bad_addr      rejected target, valid while o_misaligned is 1
//   o_ras_top       predicted return address (0 when the RAS is empty)
//   o_ras_empty     RAS holds no entries
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = XLEN'(32'h8000_0000),
  parameter int unsigned          INC          = 4,
  parameter int unsigned          RAS_DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load_PC,
  input  logic            i_jump_DV,
  input  logic [XLEN-1:0] i_jump_address,
  input  logic            i_call,
  input  logic            i_ret,
  input  logic            i_trap,
  input  logic [XLEN-1:0] i_trap_vector,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_mepc,
  output logic [XLEN-1:0] o_PC,
  output logic [XLEN-1:0] o_prev_PC,
  output logic            o_misaligned,
  output logic [XLEN-1:0] o_bad_addr,
  output logic [XLEN-1:0] o_ras_top,
  output logic            o_ras_empty
);

  localparam int unsigned LSB_W = $clog2(INC);
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [XLEN-1:0]  C_INC      = XLEN'(INC);
  localparam logic [XLEN-1:0]  C_WORD_MSK = ~XLEN'(3);
  localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_prev_pc;
  logic             r_misaligned;
  logic [XLEN-1:0]  r_bad_addr;
  logic [XLEN-1:0]  r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_ras_ptr;
  logic [CNT_W-1:0] r_ras_cnt;

  logic             w_jump;
  logic             w_accept;
  logic             w_reject;
  logic             w_pc_upd;
  logic [XLEN-1:0]  w_pc_next;
  logic [XLEN-1:0]  w_ret_addr;
  logic [PTR_W-1:0] w_top_idx;
  logic             w_ras_wr;
  logic [PTR_W-1:0] w_ras_widx;
  logic [PTR_W-1:0] w_ptr_next;
  logic [CNT_W-1:0] w_cnt_next;

  // Trap and mret take precedence, so a jump only counts when neither is set.
  assign w_jump     = i_load_PC & i_jump_DV & ~i_trap & ~i_mret;
  assign w_accept   = w_jump & (i_jump_address[LSB_W-1:0] == '0);
  assign w_reject   = w_jump & ~w_accept;
  // A rejected jump is the only i_load_PC case in which the PC does not move.
  assign w_pc_upd   = i_trap | i_mret | w_accept | (i_load_PC & ~i_jump_DV);
  assign w_ret_addr = r_pc + C_INC;
  assign w_top_idx  = r_ras_ptr - PTR_W'(1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_pc_next = r_pc + C_INC;
    if (i_trap)        w_pc_next = i_trap_vector & C_WORD_MSK;
    else if (i_mret)   w_pc_next = i_mepc & C_WORD_MSK;
    else if (i_jump_DV) w_pc_next = i_jump_address;
  end

  // RAS control: writes at ptr for a push, at ptr-1 for a swap.
  always_comb begin
    w_ras_wr   = 1'b0;
    w_ras_widx = r_ras_ptr;
    w_ptr_next = r_ras_ptr;
    w_cnt_next = r_ras_cnt;
    if (w_accept) begin
      if (i_call && (!i_ret || r_ras_cnt == '0)) begin
        // Push; when full the oldest entry is overwritten by the wrap.
        w_ras_wr   = 1'b1;
        w_ptr_next = r_ras_ptr + PTR_W'(1);
        if (r_ras_cnt != C_FULL) w_cnt_next = r_ras_cnt + CNT_W'(1);
      end else if (i_call && i_ret) begin
        w_ras_wr   = 1'b1;
        w_ras_widx = w_top_idx;
      end else if (i_ret && r_ras_cnt != '0) begin
        w_ptr_next = w_top_idx;
        w_cnt_next = r_ras_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      r_pc         <= RESET_VECTOR;
      r_prev_pc    <= RESET_VECTOR;
      r_misaligned <= 1'b0;
      r_bad_addr   <= '0;
      r_ras_ptr    <= '0;
      r_ras_cnt    <= '0;
    end else begin
      r_misaligned <= w_reject;
      if (w_reject) r_bad_addr <= i_jump_address;
      if (w_pc_upd) begin
        r_prev_pc <= r_pc;
        r_pc      <= w_pc_next;
      end
      r_ras_ptr <= w_ptr_next;
      r_ras_cnt <= w_cnt_next;
    end
  end

  // NOTE: RAS entries are not reset; the count alone defines which entries
  // are live, and o_ras_top is forced to 0 while the count is zero.
  always_ff @(posedge i_clk) begin
    if (w_ras_wr) r_ras[w_ras_widx] <= w_ret_addr;
  end

  assign o_PC         = r_pc;
  assign o_prev_PC    = r_prev_pc;
  assign o_misaligned = r_misaligned;
  assign o_bad_addr   = r_bad_addr;
  assign o_ras_empty  = (r_ras_cnt == '0);
  assign o_ras_top    = (r_ras_cnt == '0) ? '0 : r_ras[w_top_idx];

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Drives pc_sequencer (default build) with directed scenarios and randomized
// traffic, comparing every cycle against a behavioural model that keeps the
// PC as a plain integer and the RAS as a bounded queue. A second instance
// (XLEN=16, INC=2) covers the narrow/half-word alignment build.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam logic [31:0] RV    = 32'h8000_0000;
  localparam int          INC   = 4;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, load, jdv, call, ret, trap, mret;
  logic [31:0] jaddr, tvec, mepc;
  logic [31:0] pc, prev_pc, bad_addr, ras_top;
  logic        misaligned, ras_empty;

  logic        s_rst, s_load, s_jdv;
  logic [15:0] s_jaddr;
  logic [15:0] s_pc, s_prev_pc, s_bad_addr, s_ras_top;
  logic        s_misaligned, s_ras_empty;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  logic [31:0] m_pc, m_prev, m_bad;
  logic        m_mis;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_sequencer u_dut (
    .i_clk(clk), .i_rst(rst), .i_load_PC(load), .i_jump_DV(jdv),
    .i_jump_address(jaddr), .i_call(call), .i_ret(ret), .i_trap(trap),
    .i_trap_vector(tvec), .i_mret(mret), .i_mepc(mepc),
    .o_PC(pc), .o_prev_PC(prev_pc), .o_misaligned(misaligned),
    .o_bad_addr(bad_addr), .o_ras_top(ras_top), .o_ras_empty(ras_empty)
  );

  pc_sequencer #(.XLEN(16), .RESET_VECTOR(16'h0100), .INC(2), .RAS_DEPTH(4)) u_dut16 (
    .i_clk(clk), .i_rst(s_rst), .i_load_PC(s_load), .i_jump_DV(s_jdv),
    .i_jump_address(s_jaddr), .i_call(1'b0), .i_ret(1'b0), .i_trap(1'b0),
    .i_trap_vector(16'h0), .i_mret(1'b0), .i_mepc(16'h0),
    .o_PC(s_pc), .o_prev_PC(s_prev_pc), .o_misaligned(s_misaligned),
    .o_bad_addr(s_bad_addr), .o_ras_top(s_ras_top), .o_ras_empty(s_ras_empty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the specification's rules, on sampled inputs.
  task automatic model_step();
    logic [31:0] ra;
    ra = m_pc + INC;
    if (rst) begin
      m_pc = RV; m_prev = RV; m_mis = 1'b0; m_bad = '0;
      m_ras.delete();
    end else if (trap) begin
      m_prev = m_pc; m_pc = tvec & 32'hFFFF_FFFC; m_mis = 1'b0;
    end else if (mret) begin
      m_prev = m_pc; m_pc = mepc & 32'hFFFF_FFFC; m_mis = 1'b0;
    end else if (load && jdv) begin
      if (jaddr % INC == 0) begin
        if (call && !ret) begin
          m_ras.push_back(ra);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (ret && !call) begin
          if (m_ras.size() > 0) void'(m_ras.pop_back());
        end else if (call && ret) begin
          if (m_ras.size() == 0) m_ras.push_back(ra);
          else m_ras[m_ras.size()-1] = ra;
        end
        m_prev = m_pc; m_pc = jaddr; m_mis = 1'b0;
      end else begin
        m_mis = 1'b1; m_bad = jaddr;
      end
    end else if (load) begin
      m_prev = m_pc; m_pc = m_pc + INC; m_mis = 1'b0;
    end else begin
      m_mis = 1'b0;
    end
  endtask

  // Model advances on each rising edge; outputs are compared on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (chk_en) begin
        check("pc", pc, m_pc);
        check("prev_pc", prev_pc, m_prev);
        check("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
        if (m_mis) check("bad_addr", bad_addr, m_bad);
        check("ras_empty", {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
        check("ras_top", ras_top, (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size()-1]);
      end
    end
  end

  task automatic clear_in();
    rst = 0; load = 0; jdv = 0; call = 0; ret = 0; trap = 0; mret = 0;
    jaddr = '0; tvec = '0; mepc = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load();
    clear_in(); load = 1; tick();
  endtask

  task automatic do_jump(input logic [31:0] a, input logic c, input logic r);
    clear_in(); load = 1; jdv = 1; jaddr = a; call = c; ret = r; tick();
  endtask

  initial begin
    clear_in();
    rst = 1; s_rst = 1; s_load = 0; s_jdv = 0; s_jaddr = '0;
    tick();
    chk_en = 1'b1;
    s_rst = 0;

    // Reset and sequential
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_prev", prev_pc, 32'h8000_0000);
    check("rst_empty", {31'b0, ras_empty}, 32'd1);
    check("rst_top", ras_top, 32'h0);
    do_load(); check("seq1", pc, 32'h8000_0004);
    do_load(); check("seq2", pc, 32'h8000_0008);
    do_load(); check("seq3", pc, 32'h8000_000C);
    check("seq_empty", {31'b0, ras_empty}, 32'd1);
    do_load(); check("seq4", pc, 32'h8000_0010);

    // Jump, misalign and hold
    do_jump(32'h8000_0102, 0, 0);
    check("mis_pc", pc, 32'h8000_0010);
    check("mis_flag", {31'b0, misaligned}, 32'd1);
    check("mis_bad", bad_addr, 32'h8000_0102);
    do_jump(32'h8000_0100, 0, 0);
    check("jmp_pc", pc, 32'h8000_0100);
    check("jmp_prev", prev_pc, 32'h8000_0010);
    check("mis_clear", {31'b0, misaligned}, 32'd0);
    clear_in(); jdv = 1; jaddr = 32'h8000_0400; tick();
    check("hold_pc", pc, 32'h8000_0100);

    // Priority
    clear_in(); trap = 1; mret = 1; load = 1; jdv = 1; jaddr = 32'h8000_0500;
    tvec = 32'h8000_1003; mepc = 32'h8000_0600; tick();
    check("trap_pc", pc, 32'h8000_1000);
    clear_in(); mret = 1; mepc = 32'h8000_0020; tick();
    check("mret_pc", pc, 32'h8000_0020);
    clear_in(); rst = 1; trap = 1; tvec = 32'h8000_2000; tick();
    check("rst_trap_pc", pc, 32'h8000_0000);

    // RAS overflow and underflow: calls from A0..A4
    do_jump(32'h8000_0300, 0, 0);
    for (int k = 0; k < 5; k++) do_jump(32'h8000_0400 + 32'h100 * k, 1, 0);
    check("ras_top5", ras_top, 32'h8000_0704);
    do_jump(32'h8000_0900, 0, 1); check("ras_pop1", ras_top, 32'h8000_0604);
    do_jump(32'h8000_0900, 0, 1); check("ras_pop2", ras_top, 32'h8000_0504);
    do_jump(32'h8000_0900, 0, 1); check("ras_pop3", ras_top, 32'h8000_0404);
    do_jump(32'h8000_0900, 0, 1); check("ras_pop4_empty", {31'b0, ras_empty}, 32'd1);
    do_jump(32'h8000_0900, 0, 1); check("ras_pop5_empty", {31'b0, ras_empty}, 32'd1);
    check("ras_pop5_top", ras_top, 32'h0);

    // Coroutine swap
    do_jump(32'h8000_0040, 0, 0);
    do_jump(32'h8000_0080, 1, 0);
    check("co_top0", ras_top, 32'h8000_0044);
    do_jump(32'h8000_0200, 0, 0);
    do_jump(32'h8000_0300, 1, 1);
    check("co_top1", ras_top, 32'h8000_0204);
    do_jump(32'h8000_0310, 0, 1);
    check("co_count1", {31'b0, ras_empty}, 32'd1);

    // Wrap-around
    do_jump(32'hFFFF_FFFC, 0, 0);
    do_load();
    check("wrap_pc", pc, 32'h0000_0000);
    check("wrap_prev", prev_pc, 32'hFFFF_FFFC);

    // XLEN=16, INC=2 build
    s_load = 1; s_jdv = 1; s_jaddr = 16'h0102; tick();
    check("x16_accept", {16'h0, s_pc}, 32'h0102);
    s_jaddr = 16'h0103; tick();
    check("x16_mis", {31'b0, s_misaligned}, 32'd1);
    check("x16_bad", {16'h0, s_bad_addr}, 32'h0103);
    check("x16_hold", {16'h0, s_pc}, 32'h0102);
    s_jdv = 0; tick();
    check("x16_seq", {16'h0, s_pc}, 32'h0104);
    s_load = 0;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      clear_in();
      rst   = ($urandom_range(0, 59) == 0);
      trap  = ($urandom_range(0, 15) == 0);
      mret  = ($urandom_range(0, 15) == 0);
      load  = ($urandom_range(0, 3) != 0);
      jdv   = ($urandom_range(0, 2) == 0);
      call  = ($urandom_range(0, 2) == 0);
      ret   = ($urandom_range(0, 2) == 0);
      jaddr = $urandom;
      if ($urandom_range(0, 3) != 0) jaddr = jaddr & 32'hFFFF_FFFC;
      tvec  = $urandom;
      mepc  = $urandom;
      tick();
    end

    clear_in();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
